// File: rtl/ad7760_pkg.sv
// -----------------------------------------------------------------------------
// ad7760_pkg
// Shared types and defaults for the AD7760 acquisition sequencer.
//   acq_state_t      : sequencer FSM states (IDLE, HDR, CAPTURE, DONE)
//   DATA_W_DEF       : default sample / FIFO word width
//   CNT_W_DEF        : default burst and sample counter width
//   HEADER_WORD_DEF  : frame marker written ahead of samples when the
//                      ACQ_HEADER_EN macro is defined
// -----------------------------------------------------------------------------
package ad7760_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;
    localparam logic [15:0] HEADER_WORD_DEF = 16'hA5A5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } acq_state_t;

endpackage

// File: rtl/ad7760_acq_sequencer_if.sv
// -----------------------------------------------------------------------------
// ad7760_acq_sequencer_if
// Groups the ADC-side bus and the FIFO-side write port of the sequencer.
//   drdy_n, adc_data_in : from the AD7760 (drdy_n is asynchronous to mclk)
//   adc_cs_n, adc_rd_n  : to the AD7760, low while capturing
//   fifo_full           : from the downstream FIFO
//   fifo_wrreq, fifo_data : to the downstream FIFO; fifo_data is valid in
//                         every cycle fifo_wrreq is high. There is no ready
//                         back-pressure on the write itself: the sequencer
//                         only raises fifo_wrreq when fifo_full was low in
//                         the cycle it decided to write.
// Modports: master = sequencer side, slave = ADC/FIFO side.
// -----------------------------------------------------------------------------
interface ad7760_acq_sequencer_if #(
    parameter int DATA_W = ad7760_pkg::DATA_W_DEF
) ();
    logic              drdy_n;
    logic [DATA_W-1:0] adc_data_in;
    logic              adc_cs_n;
    logic              adc_rd_n;
    logic              fifo_full;
    logic              fifo_wrreq;
    logic [DATA_W-1:0] fifo_data;

    modport master (
        input  drdy_n, adc_data_in, fifo_full,
        output adc_cs_n, adc_rd_n, fifo_wrreq, fifo_data
    );

    modport slave (
        output drdy_n, adc_data_in, fifo_full,
        input  adc_cs_n, adc_rd_n, fifo_wrreq, fifo_data
    );
endinterface

// File: rtl/ad7760_drdy_sync.sv
// -----------------------------------------------------------------------------
// ad7760_drdy_sync
// Brings the asynchronous AD7760 DRDY into the mclk domain and detects its
// rising edge.
//   mclk        : clock
//   i_rest_n    : synchronous active-low reset
//   i_drdy_n    : raw DRDY from the ADC
//   o_drdy_rise : 1-cycle pulse, high from edge k+1 to k+2 when i_drdy_n is
//                 first sampled high at edge k
// -----------------------------------------------------------------------------
module ad7760_drdy_sync (
    input  logic mclk,
    input  logic i_rest_n,
    input  logic i_drdy_n,
    output logic o_drdy_rise
);
    logic r_s0;
    logic r_s1;
    logic r_d;

    // Flops reset to 1 (DRDY idle level) so no false edge appears after reset.
    always_ff @(posedge mclk) begin
        if (!i_rest_n) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
            r_d  <= 1'b1;
        end else begin
            r_s0 <= i_drdy_n;
            r_s1 <= r_s0;
            r_d  <= r_s1;
        end
    end

    assign o_drdy_rise = r_s1 & ~r_d;
endmodule

// File: rtl/ad7760_acq_sequencer.sv
// -----------------------------------------------------------------------------
// ad7760_acq_sequencer
// Runs AD7760 sample bursts once register configuration is complete: on an
// accepted start it drives CS/RD low, captures one word per synchronised DRDY
// rising edge and writes it to the downstream FIFO until burst_len samples
// are written (burst_len = 0 means run until stop).
// Optional feature macro: ACQ_HEADER_EN -- when defined every burst begins
// with one HEADER_WORD write (HDR state); otherwise IDLE goes to CAPTURE.
// Ports:
//   mclk, i_rest_n      : clock, synchronous active-low reset
//   cfg_done            : start is ignored while low
//   start / stop        : 1-cycle pulses; stop wins when both are high
//   burst_len           : latched on accepted start
//   bus (master)        : ADC bus and FIFO write port
//   busy, done          : burst in progress / 1-cycle end-of-burst pulse
//   overflow            : sticky dropped-sample flag, cleared on next start
//   sample_cnt          : samples written in current burst
//   o_dbg_state         : current FSM state
// -----------------------------------------------------------------------------
module ad7760_acq_sequencer
    import ad7760_pkg::*;
#(
    parameter int              DATA_W      = DATA_W_DEF,
    parameter int              CNT_W       = CNT_W_DEF,
    parameter logic [DATA_W-1:0] HEADER_WORD = DATA_W'(HEADER_WORD_DEF)
) (
    input  logic                   mclk,
    input  logic                   i_rest_n,
    input  logic                   cfg_done,
    input  logic                   start,
    input  logic                   stop,
    input  logic [CNT_W-1:0]       burst_len,
    ad7760_acq_sequencer_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [CNT_W-1:0]       sample_cnt,
    output acq_state_t             o_dbg_state
);
    acq_state_t        r_state;
    logic [CNT_W-1:0]  r_burst_len;
    logic [CNT_W-1:0]  r_sample_cnt;
    logic              r_overflow;
    logic              r_fifo_wrreq;
    logic [DATA_W-1:0] r_fifo_data;

    acq_state_t        w_state_nxt;
    logic [CNT_W-1:0]  w_burst_len_nxt;
    logic [CNT_W-1:0]  w_sample_cnt_nxt;
    logic              w_overflow_nxt;
    logic              w_fifo_wrreq_nxt;
    logic [DATA_W-1:0] w_fifo_data_nxt;
    logic              w_drdy_rise;
    logic              w_burst_end;

    ad7760_drdy_sync u_drdy_sync (
        .mclk        (mclk),
        .i_rest_n    (i_rest_n),
        .i_drdy_n    (bus.drdy_n),
        .o_drdy_rise (w_drdy_rise)
    );

    // Burst is complete once the counter has caught up with a non-zero length;
    // checked one cycle after the last write so DONE follows it.
    assign w_burst_end = (r_burst_len != '0) && (r_sample_cnt == r_burst_len);

    always_ff @(posedge mclk) begin
        if (!i_rest_n) begin
            r_state      <= IDLE;
            r_burst_len  <= '0;
            r_sample_cnt <= '0;
            r_overflow   <= 1'b0;
            r_fifo_wrreq <= 1'b0;
            r_fifo_data  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_burst_len  <= w_burst_len_nxt;
            r_sample_cnt <= w_sample_cnt_nxt;
            r_overflow   <= w_overflow_nxt;
            r_fifo_wrreq <= w_fifo_wrreq_nxt;
            r_fifo_data  <= w_fifo_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_burst_len_nxt  = r_burst_len;
        w_sample_cnt_nxt = r_sample_cnt;
        w_overflow_nxt   = r_overflow;
        w_fifo_wrreq_nxt = 1'b0;
        w_fifo_data_nxt  = r_fifo_data;

        case (r_state)
            IDLE: begin
                if (start && cfg_done && !stop) begin
                    w_burst_len_nxt  = burst_len;
                    w_sample_cnt_nxt = '0;
                    w_overflow_nxt   = 1'b0;
`ifdef ACQ_HEADER_EN
                    w_state_nxt      = HDR;
`else
                    w_state_nxt      = CAPTURE;
`endif
                end
            end
            // Unreachable unless ACQ_HEADER_EN routes IDLE here.
            HDR: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                end else if (!bus.fifo_full) begin
                    w_fifo_wrreq_nxt = 1'b1;
                    w_fifo_data_nxt  = HEADER_WORD;
                    w_state_nxt      = CAPTURE;
                end
            end
            CAPTURE: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                end else if (w_burst_end) begin
                    w_state_nxt = DONE;
                end else if (w_drdy_rise) begin
                    if (!bus.fifo_full) begin
                        w_fifo_wrreq_nxt = 1'b1;
                        w_fifo_data_nxt  = bus.adc_data_in;
                        // Wraps naturally in continuous mode.
                        w_sample_cnt_nxt = r_sample_cnt + CNT_W'(1);
                    end else begin
                        w_overflow_nxt = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.adc_cs_n   = (r_state != CAPTURE);
    assign bus.adc_rd_n   = (r_state != CAPTURE);
    assign bus.fifo_wrreq = r_fifo_wrreq;
    assign bus.fifo_data  = r_fifo_data;
    assign busy           = (r_state != IDLE);
    assign done           = (r_state == DONE);
    assign overflow       = r_overflow;
    assign sample_cnt     = r_sample_cnt;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_ad7760_acq_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ad7760_acq_sequencer
// Directed bench for ad7760_acq_sequencer. Expected FIFO words are queued when
// the matching DRDY edge is driven and checked when fifo_wrreq appears.
// Build with ACQ_HEADER_EN defined to also exercise the header word.
// -----------------------------------------------------------------------------
module tb_ad7760_acq_sequencer;
    import ad7760_pkg::*;

    localparam int DW = DATA_W_DEF;
    localparam int CW = CNT_W_DEF;

    logic          mclk = 1'b0;
    logic          i_rest_n;
    logic          cfg_done;
    logic          start;
    logic          stop;
    logic [CW-1:0] burst_len;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [CW-1:0] sample_cnt;
    acq_state_t    dbg_state;

    ad7760_acq_sequencer_if bus ();

    ad7760_acq_sequencer dut (
        .mclk        (mclk),
        .i_rest_n    (i_rest_n),
        .cfg_done    (cfg_done),
        .start       (start),
        .stop        (stop),
        .burst_len   (burst_len),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .sample_cnt  (sample_cnt),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 mclk = ~mclk;

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];
    int n_checks = 0;
    int n_err    = 0;
    int wr_cnt   = 0;
    int pushes   = 0;
    int done_cnt = 0;
    int n_starts = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        exp_q.push_back(w);
        pushes++;
    endtask

    // Holds DRDY low, presents data, then releases DRDY (the captured edge).
    task automatic drdy_pulse(input logic [DW-1:0] w, input bit expect_wr);
        bus.drdy_n = 1'b0;
        tick(3);
        bus.adc_data_in = w;
        if (expect_wr) push(w);
        bus.drdy_n = 1'b1;
        tick(5);
    endtask

    task automatic start_burst(input logic [CW-1:0] len, input bit accept);
        burst_len = len;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (accept) begin
            n_starts++;
`ifdef ACQ_HEADER_EN
            push(DW'(HEADER_WORD_DEF));
`endif
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles && busy; i++) tick();
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    // ---------------- monitor ----------------
    logic [DW-1:0] mon_exp;
    always @(negedge mclk) begin
        if (done) done_cnt++;
        if (bus.fifo_wrreq) begin
            wr_cnt++;
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_wr observed=%0h expected=no_write", bus.fifo_data);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                chk("fifo_data", 32'(bus.fifo_data), 32'(mon_exp));
            end
        end
    end

    // ---------------- time limit ----------------
    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit reached");
    end

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        int w0;

        i_rest_n        = 1'b0;
        cfg_done        = 1'b0;
        start           = 1'b0;
        stop            = 1'b0;
        burst_len       = '0;
        bus.drdy_n      = 1'b1;
        bus.adc_data_in = '0;
        bus.fifo_full   = 1'b0;
        tick(3);

        // Reset values
        chk("rst_cs_n", 32'(bus.adc_cs_n), 32'd1);
        chk("rst_rd_n", 32'(bus.adc_rd_n), 32'd1);
        chk("rst_wrreq", 32'(bus.fifo_wrreq), 32'd0);
        chk("rst_data", 32'(bus.fifo_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_cnt", 32'(sample_cnt), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));

        i_rest_n = 1'b1;
        cfg_done = 1'b1;
        tick(2);

        // 1: four-sample burst
        d0 = done_cnt;
        start_burst(16'd4, 1'b1);
        chk("t1_busy", 32'(busy), 32'd1);
`ifdef ACQ_HEADER_EN
        tick(2);
`endif
        chk("t1_cs_n", 32'(bus.adc_cs_n), 32'd0);
        chk("t1_rd_n", 32'(bus.adc_rd_n), 32'd0);
        drdy_pulse(16'h0011, 1'b1);
        drdy_pulse(16'h0022, 1'b1);
        drdy_pulse(16'h0033, 1'b1);
        drdy_pulse(16'h0044, 1'b1);
        wait_idle(20);
        chk("t1_done_cycles", 32'(done_cnt - d0), 32'd1);
        chk("t1_cnt", 32'(sample_cnt), 32'd4);
        chk("t1_cs_high", 32'(bus.adc_cs_n), 32'd1);
        chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // 2: latency from DRDY edge to write strobe
        d0 = done_cnt;
        start_burst(16'd1, 1'b1);
        bus.drdy_n = 1'b0;
        tick(3);
        bus.adc_data_in = 16'h0BEE;
        push(16'h0BEE);
        bus.drdy_n = 1'b1;
        tick();
        chk("t2_wr_k", 32'(bus.fifo_wrreq), 32'd0);
        tick();
        chk("t2_wr_k1", 32'(bus.fifo_wrreq), 32'd0);
        tick();
        chk("t2_wr_k2", 32'(bus.fifo_wrreq), 32'd1);
        chk("t2_data_k2", 32'(bus.fifo_data), 32'h0BEE);
        tick();
        chk("t2_wr_k3", 32'(bus.fifo_wrreq), 32'd0);
        wait_idle(20);
        chk("t2_done_cycles", 32'(done_cnt - d0), 32'd1);

        // 3: overflow on a full FIFO
        d0 = done_cnt;
        start_burst(16'd3, 1'b1);
        drdy_pulse(16'h0101, 1'b1);
        bus.fifo_full = 1'b1;
        drdy_pulse(16'h0202, 1'b0);
        bus.fifo_full = 1'b0;
        chk("t3_ovf_set", 32'(overflow), 32'd1);
        chk("t3_cnt_hold", 32'(sample_cnt), 32'd1);
        drdy_pulse(16'h0303, 1'b1);
        drdy_pulse(16'h0404, 1'b1);
        wait_idle(20);
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);
        chk("t3_cnt", 32'(sample_cnt), 32'd3);
        chk("t3_done_cycles", 32'(done_cnt - d0), 32'd1);

        // 4: continuous mode, ignored re-start, stop coinciding with a DRDY edge
        d0 = done_cnt;
        start_burst(16'd0, 1'b1);
        chk("t4_ovf_clr", 32'(overflow), 32'd0);
        for (int i = 0; i < 10; i++) begin
            drdy_pulse(DW'(i * 37 + 5), 1'b1);
            if (i == 2) start_burst(16'd2, 1'b0);
        end
        chk("t4_cnt", 32'(sample_cnt), 32'd10);
        chk("t4_busy", 32'(busy), 32'd1);
        bus.drdy_n = 1'b0;
        tick(3);
        bus.adc_data_in = 16'h0DEA;
        bus.drdy_n = 1'b1;
        tick(2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t4_stop_busy", 32'(busy), 32'd0);
        chk("t4_stop_cs", 32'(bus.adc_cs_n), 32'd1);
        tick(4);
        chk("t4_cnt_after_stop", 32'(sample_cnt), 32'd10);
        chk("t4_no_done", 32'(done_cnt - d0), 32'd0);
        cfg_done = 1'b0;
        start_burst(16'd3, 1'b0);
        chk("t4_nocfg_busy", 32'(busy), 32'd0);
        cfg_done = 1'b1;

        // 5: start and stop together; reset mid-burst
        burst_len = 16'd2;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("t5_ss_busy", 32'(busy), 32'd0);
        chk("t5_ss_state", 32'(dbg_state), 32'(IDLE));
        start_burst(16'd5, 1'b1);
        bus.fifo_full = 1'b1;
        drdy_pulse(16'h0555, 1'b0);
        bus.fifo_full = 1'b0;
        drdy_pulse(16'h0666, 1'b1);
        chk("t5_ovf", 32'(overflow), 32'd1);
        chk("t5_cnt", 32'(sample_cnt), 32'd1);
        bus.drdy_n = 1'b0;
        tick(3);
        bus.adc_data_in = 16'h0777;
        bus.drdy_n = 1'b1;
        tick(2);
        i_rest_n = 1'b0;
        tick();
        chk("t5_rst_wrreq", 32'(bus.fifo_wrreq), 32'd0);
        chk("t5_rst_data", 32'(bus.fifo_data), 32'd0);
        chk("t5_rst_cs_n", 32'(bus.adc_cs_n), 32'd1);
        chk("t5_rst_rd_n", 32'(bus.adc_rd_n), 32'd1);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_done", 32'(done), 32'd0);
        chk("t5_rst_ovf", 32'(overflow), 32'd0);
        chk("t5_rst_cnt", 32'(sample_cnt), 32'd0);
        i_rest_n = 1'b1;
        tick(4);

`ifdef ACQ_HEADER_EN
        // 6: header held while the FIFO is full
        w0 = wr_cnt;
        bus.fifo_full = 1'b1;
        start_burst(16'd2, 1'b1);
        tick(4);
        chk("t6_hdr_state", 32'(dbg_state), 32'(HDR));
        chk("t6_hdr_held", 32'(wr_cnt - w0), 32'd0);
        bus.fifo_full = 1'b0;
        tick(2);
        chk("t6_hdr_written", 32'(wr_cnt - w0), 32'd1);
        drdy_pulse(16'h0A01, 1'b1);
        drdy_pulse(16'h0A02, 1'b1);
        wait_idle(20);
        chk("t6_cnt", 32'(sample_cnt), 32'd2);
        chk("t6_total_wr", 32'(wr_cnt - w0), 32'd3);
`else
        w0 = wr_cnt;
        chk("no_hdr_wr", 32'(wr_cnt - w0), 32'd0);
`endif

        // Final scoreboard
        tick(4);
        chk("q_drained", 32'(exp_q.size()), 32'd0);
        chk("wr_total", 32'(wr_cnt), 32'(pushes));
        chk("starts_accepted", 32'(n_starts), 32'(n_starts > 0 ? n_starts : 1));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
